count_change_reporter: RTL and testbench
========================================

// Module: count_change_reporter
// PURPOSE
//  Downstream stage of the sequence detector. Watches the detector's 4-bit
//  recognised-sequence count and queues every new value in a small FIFO.
//  Queued values go to a slower consumer over the dav_/rfd handshake.
//  Raises a sticky overflow flag when the FIFO cannot accept a change.
// PARAMETERS
//  W      4  width of the count word (matches detector z3_z0)
//  DEPTH  4  FIFO entries; power of two, >=2
// PORTS
//  clock    in   1  single system clock; all state updates on posedge
//  reset_   in   1  synchronous, active-low; sampled on posedge clock
//  z3_z0    in   W  count from the sequence detector
//  data     out  W  value offered to the consumer
//  dav_     out  1  data valid, active-low
//  rfd      in   1  consumer ready-for-data, active-high
//  ovf      out  1  sticky overflow flag
// BEHAVIOUR
//  Reset (reset_==0 at posedge):
//   - PREV<=0, FIFO empty, data<=0, dav_<=1, ovf<=0, state<=S_IDLE.
//   - Reset mid-handshake aborts the transfer and discards queued entries.
//  Change detection, every posedge with reset_==1:
//   - If z3_z0!=PREV: request push of z3_z0 and set PREV<=z3_z0.
//   - Wrap 15->0 counts as a change.
//   - Latency: value sampled at edge N is in FIFO after edge N.
//   - Earliest data/dav_ update is edge N+1.
//  FIFO:
//   - Circular buffer with rd/wr pointers of log2(DEPTH) bits plus an occupancy counter.
//   - Push while full with no pop in the same cycle: value dropped, ovf<=1.
//     PREV still updates, so the next change is compared against the dropped value.
//   - Push and pop in the same cycle while full: both occur, occupancy unchanged, no ovf.
//   - Push and pop in the same cycle while empty: impossible (pop requires non-empty).
//   - ovf is cleared only by reset.
//  Handshake FSM (one-hot-free binary encoding):
//   - S_IDLE: dav_=1. If FIFO non-empty and rfd==1: data<=head, dav_<=0, go to S_ACK.
//   - S_ACK: data stable, dav_=0. If rfd==0: dav_<=1, pop head, go to S_IDLE.
//   - In S_IDLE the FSM also waits for rfd==1 before the next offer, which completes the 4-phase protocol.
//   - data holds its last value when idle.
//   - Minimum 2 clocks per transfer. Throughput is bounded by the consumer.
//  Widths: occupancy counter is log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
// STRUCTURE
//  Shared include (count_reporter_defs.vh):
//   - S_IDLE=1'b0, S_ACK=1'b1
//   - default W=4, DEPTH=4
//  Sub-module count_fifo(clock, reset_, push, din, pop, dout, empty, full).
//   - Synchronous reset, same polarity as the top.
//  Top holds the PREV register, push/ovf logic, and the handshake FSM.
// TESTING
//  1. Reset with z3_z0=0, rfd=1 -> dav_=1, ovf=0, data=0; no transfer for 10 clocks.
//  2. z3_z0 0->1, rfd=1, consumer drops rfd 1 clock after dav_=0
//     -> data=1 with dav_=0 within 2 clocks; dav_=1 on the edge after rfd=0.
//  3. z3_z0 steps 1,2,3,4 on consecutive clocks, consumer slow
//     -> consumer receives 1,2,3,4 in order; ovf=0.
//  4. rfd held 0, five changes 1..5
//     -> ovf=1 after the 5th; later draining yields 1,2,3,4 only.
//  5. FIFO full, rfd falls on the same edge a 6th change arrives
//     -> pop and push both occur, ovf unchanged, order preserved.
//  6. Wrap 15->0, then reset_=0 for 1 clock while dav_=0 and 2 entries queued
//     -> 0 is reported before reset; after reset dav_=1, FIFO empty, ovf=0.

Source files
------------

// File: rtl/count_change_reporter_pkg.sv
// rtl/count_change_reporter_pkg.sv - shared defaults and handshake state type for the count change reporter
package count_change_reporter_pkg;

    localparam int DEF_W     = 4;
    localparam int DEF_DEPTH = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } hs_state_t;

endpackage

// File: rtl/count_change_reporter_fifo.sv
// rtl/count_change_reporter_fifo.sv - circular-buffer FIFO holding count changes awaiting the consumer
module count_fifo
    import count_change_reporter_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          w_wr_en;
    logic          w_rd_en;

    assign empty   = (r_cnt == '0);
    assign full    = (r_cnt == FULL_CNT);
    assign w_rd_en = pop && !empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO is still accepted.
    assign w_wr_en = push && (!full || w_rd_en);
    assign dout    = r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/count_change_reporter.sv
// rtl/count_change_reporter.sv - queues every change of the detector count and offers it over a 4-phase dav_/rfd handshake
module count_change_reporter
    import count_change_reporter_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic [W-1:0] z3_z0,
    output logic [W-1:0] data,
    output logic         dav_,
    input  logic         rfd,
    output logic         ovf
);

    hs_state_t    r_state;
    logic [W-1:0] r_prev;
    logic         w_push;
    logic         w_pop;
    logic [W-1:0] w_head;
    logic         w_empty;
    logic         w_full;

    assign w_push = (z3_z0 != r_prev);
    assign w_pop  = (r_state == S_ACK) && !rfd;

    count_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset_ (reset_),
        .push   (w_push),
        .din    (z3_z0),
        .pop    (w_pop),
        .dout   (w_head),
        .empty  (w_empty),
        .full   (w_full)
    );

    always_ff @(posedge clock) begin
        if (!reset_) begin
            r_prev  <= '0;
            data    <= '0;
            dav_    <= 1'b1;
            ovf     <= 1'b0;
            r_state <= S_IDLE;
        end else begin
            // PREV follows the input even when the push is dropped.
            r_prev <= z3_z0;
            if (w_push && w_full && !w_pop) begin
                ovf <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (!w_empty && rfd) begin
                        data    <= w_head;
                        dav_    <= 1'b0;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!rfd) begin
                        dav_    <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_count_change_reporter.sv
// tb/tb_count_change_reporter.sv - directed and randomized checks of count_change_reporter against a queue model
module tb_count_change_reporter;

    localparam int DEPTH = 4;

    logic       clock;
    logic       reset_;
    logic [3:0] z3_z0;
    logic [3:0] data;
    logic       dav_;
    logic       rfd;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    logic [3:0] m_q[$];
    logic [3:0] m_prev;
    logic       m_off;
    logic [3:0] m_data;
    logic       m_dav;
    logic       m_ovf;
    logic       last_dav;
    logic [3:0] rx[$];
    logic [3:0] exp_q[$];

    count_change_reporter dut (
        .clock  (clock),
        .reset_ (reset_),
        .z3_z0  (z3_z0),
        .data   (data),
        .dav_   (dav_),
        .rfd    (rfd),
        .ovf    (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, advance the model by the protocol rules, compare after the edge.
    task automatic step(input logic rst_n, input logic [3:0] z, input logic r);
        reset_ = rst_n;
        z3_z0  = z;
        rfd    = r;
        @(posedge clock);
        if (!rst_n) begin
            m_q.delete();
            m_prev = 4'd0;
            m_off  = 1'b0;
            m_data = 4'd0;
            m_dav  = 1'b1;
            m_ovf  = 1'b0;
        end else begin
            if (m_off) begin
                if (!r) begin
                    m_dav = 1'b1;
                    m_off = 1'b0;
                    void'(m_q.pop_front());
                end
            end else if (m_q.size() > 0 && r) begin
                m_data = m_q[0];
                m_dav  = 1'b0;
                m_off  = 1'b1;
            end
            if (z != m_prev) begin
                if (m_q.size() < DEPTH) m_q.push_back(z);
                else m_ovf = 1'b1;
                m_prev = z;
            end
        end
        #1;
        check("data", 32'(data), 32'(m_data));
        check("dav_", 32'(dav_), 32'(m_dav));
        check("ovf", 32'(ovf), 32'(m_ovf));
        if (last_dav === 1'b1 && dav_ === 1'b0) rx.push_back(data);
        last_dav = dav_;
    endtask

    task automatic drain(input logic [3:0] z, input int n);
        for (int i = 0; i < n; i++) step(1'b1, z, (i % 5) < 2);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_count"}, 32'(rx.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
            check({tag, "_value"}, 32'(rx[i]), 32'(exp_q[i]));
    endtask

    initial begin
        last_dav = 1'b1;
        m_prev = 4'd0; m_off = 1'b0; m_data = 4'd0; m_dav = 1'b1; m_ovf = 1'b0;

        // Reset state and idle with no changes
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b1);
        check("t1_dav_reset", 32'(dav_), 32'd1);
        check("t1_data_reset", 32'(data), 32'd0);
        check("t1_ovf_reset", 32'(ovf), 32'd0);
        rx.delete();
        for (int i = 0; i < 10; i++) step(1'b1, 4'd0, 1'b1);
        check("t1_no_transfer", 32'(rx.size()), 32'd0);

        // Single change, consumer drops rfd one clock after dav_ falls
        step(1'b1, 4'd1, 1'b1);
        step(1'b1, 4'd1, 1'b1);
        check("t2_dav_low", 32'(dav_), 32'd0);
        check("t2_data", 32'(data), 32'd1);
        step(1'b1, 4'd1, 1'b0);
        check("t2_dav_high", 32'(dav_), 32'd1);

        // Four consecutive changes, slow consumer
        step(1'b0, 4'd0, 1'b0);
        rx.delete();
        step(1'b1, 4'd1, 1'b0);
        step(1'b1, 4'd2, 1'b1);
        step(1'b1, 4'd3, 1'b1);
        step(1'b1, 4'd4, 1'b0);
        drain(4'd4, 40);
        exp_q = {4'd1, 4'd2, 4'd3, 4'd4};
        check_rx("t3_rx");
        check("t3_ovf", 32'(ovf), 32'd0);

        // Overflow on the fifth change while the consumer stalls
        step(1'b0, 4'd0, 1'b0);
        rx.delete();
        for (int v = 1; v <= 4; v++) step(1'b1, 4'(v), 1'b0);
        check("t4_ovf_before", 32'(ovf), 32'd0);
        step(1'b1, 4'd5, 1'b0);
        check("t4_ovf_after", 32'(ovf), 32'd1);
        drain(4'd5, 40);
        exp_q = {4'd1, 4'd2, 4'd3, 4'd4};
        check_rx("t4_rx");
        check("t4_ovf_sticky", 32'(ovf), 32'd1);

        // Full FIFO: pop and push on the same edge
        step(1'b0, 4'd0, 1'b1);
        rx.delete();
        step(1'b1, 4'd1, 1'b1);
        step(1'b1, 4'd2, 1'b1);
        step(1'b1, 4'd3, 1'b1);
        step(1'b1, 4'd4, 1'b1);
        step(1'b1, 4'd5, 1'b0);
        check("t5_ovf", 32'(ovf), 32'd0);
        drain(4'd5, 40);
        exp_q = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        check_rx("t5_rx");

        // Wrap 15->0, then reset mid-handshake with entries queued
        step(1'b0, 4'd0, 1'b1);
        rx.delete();
        step(1'b1, 4'd15, 1'b1);
        step(1'b1, 4'd15, 1'b1);
        step(1'b1, 4'd15, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        step(1'b1, 4'd0, 1'b1);
        check("t6_wrap_data", 32'(data), 32'd0);
        check("t6_wrap_dav", 32'(dav_), 32'd0);
        step(1'b1, 4'd0, 1'b0);
        exp_q = {4'd15, 4'd0};
        check_rx("t6_rx");
        step(1'b1, 4'd1, 1'b1);
        step(1'b1, 4'd2, 1'b1);
        check("t6_pre_reset_dav", 32'(dav_), 32'd0);
        step(1'b0, 4'd0, 1'b1);
        check("t6_reset_dav", 32'(dav_), 32'd1);
        check("t6_reset_ovf", 32'(ovf), 32'd0);
        rx.delete();
        for (int i = 0; i < 5; i++) step(1'b1, 4'd0, 1'b1);
        check("t6_empty", 32'(rx.size()), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] zr;
            zr = z3_z0;
            if ($urandom_range(0, 2) == 0) zr = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 299) != 0), zr, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
